// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, request control bundle.
// No logic here; latency/backpressure are properties of dmem_responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
  } req_ctl_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering shared by store (byte enables, replicated write data) and load (lane pick, extension).
// Purely combinational, no backpressure; misaligned low bits are dropped, reserved size behaves as word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    rdata_ext  = rword;
    rbyte      = rword[8*addr_lo +: 8];
    rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sgn & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sgn & rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder; rsp_valid pulses WAIT_CYCLES+2 cycles after acceptance.
// req_ready only in IDLE/RESP; DMEM_ALIGN_CHECK_EN turns misaligned/reserved accesses into rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  req_ctl_t              ctl_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  accept;
  logic                  acc_err;
  logic [3:0]            be;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  unused_addr_hi;

  // Upper address bits alias onto the array.
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

  always_comb begin
    state_nxt = state;
    req_ready = (state == ST_IDLE) || (state == ST_RESP);
    accept    = req_valid && req_ready;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        else        state_nxt = ST_IDLE;
      end
      ST_WAIT:   if (cnt == '0) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ctl_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ctl_q   <= '{we: req_we, size: req_size, sgn: req_signed};
        addr_q  <= req_addr[DEPTH_LOG2+1:0];
        wdata_q <= req_wdata;
        cnt     <= WAIT_LOAD;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == ST_ACCESS)
        rsp_rdata <= (ctl_q.we || acc_err) ? '0 : rdata_ext;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    acc_err = 1'b0;
    case (ctl_q.size)
      SZ_HALF: acc_err = addr_q[0];
      SZ_WORD: acc_err = |addr_q[1:0];
      SZ_RSVD: acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                     rsp_err <= 1'b0;
    else if (state == ST_ACCESS) rsp_err <= acc_err;
  end
`else
  assign acc_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .size       (ctl_q.size),
    .addr_lo    (addr_q[1:0]),
    .sgn        (ctl_q.sgn),
    .wdata      (wdata_q),
    .rword      (mem[addr_q[DEPTH_LOG2+1:2]]),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // A reset coinciding with the access edge must not commit the store.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_ACCESS && ctl_q.we && !acc_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[DEPTH_LOG2+1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W      = 2;
  localparam int D      = 6;
  localparam int NBYTES = 4 << D;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] expv;
  } rq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int   nvec = 0;
  int   nerr = 0;
  logic [7:0] mb [NBYTES];
  rq_t  pend [$];

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(W), .DEPTH_LOG2(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses as runs of 1/2/4 bytes.
  function automatic void model(input rq_t r, output logic [31:0] rd, output logic er);
    int          n;
    int unsigned a;
    logic [31:0] v;
    n  = (r.sz == SZ_BYTE) ? 1 : (r.sz == SZ_HALF) ? 2 : 4;
    er = 1'b0;
    rd = '0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (r.sz == SZ_RSVD || (r.addr % n) != 0) er = 1'b1;
`endif
    if (er) return;
    a = r.addr % NBYTES;
    a = a - (a % n);
    if (r.we) begin
      for (int i = 0; i < n; i++) mb[a+i] = r.wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
      if (r.sgn && n < 4 && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  task automatic push(input logic we, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] wd, input logic chk, input logic [31:0] expv);
    rq_t r;
    r = '{we: we, sz: sz, sgn: sgn, addr: addr, wd: wd, chk: chk, expv: expv};
    pend.push_back(r);
  endtask

  task automatic drive_junk();
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Plays the pending queue; hold_valid keeps req_valid high for back-to-back issue.
  task automatic run_stream(input bit hold_valid, input int budget);
    int          cyc = 0;
    int          last_rsp = -1;
    bit          accepting = 0;
    bit          prev_rsp = 0;
    int          acc_cyc [$];
    logic [31:0] exp_d [$];
    logic        exp_e [$];
    logic        exp_c [$];
    logic [31:0] exp_v [$];
    logic [31:0] rd;
    logic        er;
    while ((pend.size() > 0 || exp_d.size() > 0 || accepting) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (accepting) begin
        void'(pend.pop_front());
        accepting = 0;
      end
      if (rsp_valid) begin
        check("rsp_not_consecutive", 32'(prev_rsp), 0);
        if (exp_d.size() == 0) begin
          check("spurious_rsp", 32'(rsp_valid), 0);
        end else begin
          check("latency", 32'(cyc - acc_cyc.pop_front()), 32'(W + 2));
          check("rdata_model", rsp_rdata, exp_d.pop_front());
          check("err_model", 32'(rsp_err), 32'(exp_e.pop_front()));
          if (exp_c.pop_front()) check("rdata_directed", rsp_rdata, exp_v.pop_front());
          else void'(exp_v.pop_front());
          if (hold_valid && last_rsp >= 0) check("rsp_spacing", 32'(cyc - last_rsp), 32'(W + 2));
          last_rsp = cyc;
        end
      end
      prev_rsp = rsp_valid;
      if (req_ready && pend.size() > 0 && (hold_valid || $urandom_range(0, 1) == 1)) begin
        req_valid  = 1'b1;
        req_we     = pend[0].we;
        req_size   = pend[0].sz;
        req_signed = pend[0].sgn;
        req_addr   = pend[0].addr;
        req_wdata  = pend[0].wd;
        model(pend[0], rd, er);
        exp_d.push_back(rd);
        exp_e.push_back(er);
        exp_c.push_back(pend[0].chk);
        exp_v.push_back(pend[0].expv);
        acc_cyc.push_back(cyc);
        accepting = 1;
      end else begin
        req_valid = (hold_valid && pend.size() > 0) ? 1'b1 : 1'(($urandom_range(0, 3) == 0) && !req_ready);
        drive_junk();
      end
    end
    req_valid = 1'b0;
    check("stream_drained", 32'(pend.size() + exp_d.size()), 0);
  endtask

  // Store accepted, then reset k cycles later (1 = during WAIT, W+1 = on the ACCESS edge).
  task automatic reset_during(input int k, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    check("rst_pre_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr  = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (k - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready_after", 32'(req_ready), 1);
    check("rst_rdata_after", rsp_rdata, 0);
    check("rst_err_after", 32'(rsp_err), 0);
    for (int i = 0; i < W + 4; i++) begin
      check("rst_no_rsp", 32'(rsp_valid), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 1);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_err", 32'(rsp_err), 0);

    for (int i = 0; i < NBYTES / 4; i++) push(1, SZ_WORD, 0, 32'(4 * i), $urandom, 0, 0);
    run_stream(1, 2000);

    push(1, SZ_WORD, 0, 32'h10, 32'h12345678, 1, 0);
    push(0, SZ_WORD, 0, 32'h10, 0, 1, 32'h12345678);
    run_stream(0, 200);

    push(1, SZ_BYTE, 0, 32'h13, 32'h000000AB, 1, 0);
    push(0, SZ_BYTE, 1, 32'h13, 0, 1, 32'hFFFFFFAB);
    push(0, SZ_BYTE, 0, 32'h13, 0, 1, 32'h000000AB);
    push(0, SZ_WORD, 0, 32'h10, 0, 1, 32'hAB345678);
    push(1, SZ_HALF, 0, 32'h12, 32'h00008001, 1, 0);
    push(0, SZ_HALF, 1, 32'h12, 0, 1, 32'hFFFF8001);
    push(0, SZ_HALF, 0, 32'h12, 0, 1, 32'h00008001);
    push(0, SZ_WORD, 0, 32'h10, 0, 1, 32'h80015678);
    run_stream(0, 400);

    push(0, SZ_WORD, 0, 32'h10, 0, 1, 32'h80015678);
    push(0, SZ_WORD, 0, 32'h10 + 32'(NBYTES), 0, 1, 32'h80015678);
    push(0, SZ_HALF, 1, 32'h10, 0, 1, 32'h00005678);
    run_stream(1, 200);

    reset_during(1, 32'h20, 32'hDEADBEEF);
    push(0, SZ_WORD, 0, 32'h20, 0, 0, 0);
    run_stream(0, 200);
    reset_during(W + 1, 32'h24, 32'hDEADBEEF);
    push(0, SZ_WORD, 0, 32'h24, 0, 0, 0);
    run_stream(0, 200);

`ifdef DMEM_ALIGN_CHECK_EN
    push(0, SZ_WORD, 0, 32'h11, 0, 1, 32'h00000000);
    push(1, SZ_HALF, 0, 32'h11, 32'h00001111, 1, 0);
    push(0, SZ_WORD, 0, 32'h10, 0, 1, 32'h80015678);
`else
    push(0, SZ_WORD, 0, 32'h11, 0, 1, 32'h80015678);
    push(1, SZ_HALF, 0, 32'h11, 32'h00001111, 1, 0);
    push(0, SZ_WORD, 0, 32'h10, 0, 1, 32'h80011111);
`endif
    run_stream(0, 200);

    for (int i = 0; i < 300; i++)
      push(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 4 * NBYTES - 1)), $urandom, 0, 0);
    run_stream(0, 20000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the MIPS core's data port. It accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs byte/half/word access with sign or zero extension on a private word-organised array. It returns a single-cycle response pulse. It sits between the core's memory stage and data storage, so the pipeline can be tested against non-zero memory latency.

## Interface
- `WAIT_CYCLES`, default 2: wait states before the array access; legal range 0..15.
- `DEPTH_LOG2`, default 10: array depth is 2^DEPTH_LOG2 32-bit words.

- `clk`  in  1  clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  sign-extend loads (lb/lh); 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result, extended; 0 for stores.
- `rsp_err`  out  1  misaligned/reserved access; driven only when the macro is defined, otherwise tied 0.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- `req_ready` = 1 in IDLE and in RESP. Acceptance is `req_valid & req_ready`; at acceptance, all `req_*` fields are captured into registers.
- Transitions:
  - Accept from IDLE/RESP: go to WAIT if `WAIT_CYCLES` > 0 (counter loads `WAIT_CYCLES`-1), else go to ACCESS.
  - WAIT: decrement the counter; at 0, go to ACCESS.
  - ACCESS: go to RESP.
  - RESP: go to WAIT/ACCESS if a new request is accepted, else go to IDLE.
- The array operation happens on the edge leaving ACCESS. `rsp_rdata`, and `rsp_err` when the macro is defined, are registered on that same edge and hold their values until the next ACCESS.
- Word index = `req_addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses alias/wrap modulo the depth.
- Stores:
  - byte: writes lane `addr[1:0]` with `wdata[7:0]`.
  - half: writes lanes `{addr[1],0}` and `{addr[1],1}` with `wdata[15:0]` (little-endian lanes).
  - word: writes all four lanes.
  - Unwritten lanes are preserved.
- Loads: select the same lanes, then sign-extend (`req_signed`=1) or zero-extend to 32 bits. `req_signed` is ignored for word loads.
- Reset:
  - FSM → IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0. Array contents are not cleared.
  - Reset asserted on the ACCESS edge suppresses the write.
  - Reset mid-WAIT discards the request; no response is produced.
- `req_*` changes while `req_ready`=0 are ignored.

## Timing
- Acceptance at edge t: array access at edge t+`WAIT_CYCLES`+1; `rsp_valid` is high in the cycle following that edge (latency `WAIT_CYCLES`+2 cycles).
- Throughput under continuous `req_valid`: one request per `WAIT_CYCLES`+2 cycles, since the next request is accepted during RESP.
- `rsp_valid` is never high for two consecutive cycles.
- Reset values: `req_ready`=1 from the first cycle after reset.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - Flagged accesses: half with `addr[0]`=1, word with `addr[1:0]`≠0, or `req_size`=11.
  - A flagged access performs no write, returns `rsp_rdata`=0, and raises `rsp_err`=1 alongside `rsp_valid`.
  - Latency is unchanged.
- Not defined:
  - Low address bits are forced aligned: `addr[0]` ignored for half, `addr[1:0]` ignored for word.
  - `req_size`=11 is treated as word.
  - `rsp_err` is constant 0.

## Structure
- `dmem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state encoding, `WAIT_CYCLES` legal maximum.
- Sub-module `dmem_lane_align` (combinational): produces byte-enable and write-data steering for stores, plus lane extraction and sign/zero extension for loads. It is instantiated once and shared by the store and load paths.

## Test plan
- `WAIT_CYCLES`=2: sw 0x12345678 @0x10, then lw @0x10 → `rsp_rdata`=0x12345678; each `rsp_valid` arrives exactly 4 cycles after its acceptance edge.
- sw 0x12345678 @0x10; sb 0xAB @0x13; lb @0x13 → 0xFFFFFFAB; lbu @0x13 → 0x000000AB; lw @0x10 → 0xAB345678.
- sh 0x8001 @0x12; lh @0x12 → 0xFFFF8001; lhu @0x12 → 0x00008001; lw @0x10 → 0x8001xxxx with the low half unchanged.
- `req_valid` held high for three loads: second and third accepted in RESP cycles; `rsp_valid` pulses spaced 4 cycles apart; wrap check: lw @(0x10 + 4·2^DEPTH_LOG2) returns the same data as @0x10.
- Reset pulsed during WAIT of sw 0xDEADBEEF @0x20 → no `rsp_valid`; `req_ready`=1 the next cycle; lw @0x20 returns the prior value.
- lw @0x11: with `DMEM_ALIGN_CHECK_EN` → `rsp_err`=1, `rsp_rdata`=0, and sh @0x11 leaves memory unchanged; without the macro → returns the word @0x10, `rsp_err`=0.
